// File: rtl/enc_tx_buffer_if.sv
// Byte-in / serial-out bundle for the cipher TX buffer.
// The upstream byte handshake and the link-side status outputs travel together.
interface enc_tx_buffer_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]    din;
    logic          din_valid;
    logic          din_ready;
    logic          tx;
    logic          busy;
    logic [CW-1:0] count;
    logic          overflow;

    // Producer side: offers bytes, observes the line and the status
    modport master (
        output din, din_valid,
        input  din_ready, tx, busy, count, overflow
    );

    // Buffer side
    modport slave (
        input  din, din_valid,
        output din_ready, tx, busy, count, overflow
    );
endinterface

// File: rtl/enc_tx_buffer.sv
// Cipher byte TX buffer: small FIFO feeding a UART-style serialiser.
// Frame = start(0), 8 data bits LSB first, even parity, stop(1);
// every bit is held for CLKS_PER_BIT cycles.
module enc_tx_buffer #(
    parameter int DEPTH        = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic           CLK,
    input  logic           RST,
    enc_tx_buffer_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] FULL   = CW'(DEPTH);
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [2:0]           bit_q, bit_d;
    logic [7:0]           shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 ovf_q, ovf_d;
    logic [PW-1:0]        wptr_q, wptr_d;
    logic [PW-1:0]        rptr_q, rptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [DEPTH-1:0][7:0] mem_q, mem_d;

    logic push;
    logic pop;
    logic bit_end;

    // A bit period ends when the cycle counter reaches its last value.
    // Pops happen only when a frame starts: from IDLE, or chained straight
    // off the final STOP cycle so back-to-back frames carry no idle gap.
    // Both decisions use the pre-edge count, so a full FIFO rejects a push
    // even on the edge where it also pops.
    assign bit_end = (tick_q == T_LAST);
    assign pop     = (count_q != '0) &&
                     ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));
    assign push    = bus.din_valid && (count_q != FULL);

    // FIFO storage, pointers, occupancy and the sticky overflow flag
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (push) begin
            mem_d[wptr_q] = bus.din;
            wptr_d        = wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (bus.din_valid && (count_q == FULL)) begin
            ovf_d = 1'b1;
        end
    end

    // Serialiser next state; tx is derived from the next state so the line
    // changes together with the state register
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = 1'b1;
        if (pop) begin
            state_d = S_START;
            tick_d  = '0;
            bit_d   = '0;
            shift_d = mem_q[rptr_q];
            par_d   = ^mem_q[rptr_q];
        end else begin
            case (state_q)
                S_IDLE: begin
                    tick_d = '0;
                end
                S_START: begin
                    if (bit_end) begin
                        state_d = S_DATA;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        tick_d  = '0;
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_d = S_PARITY;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        state_d = S_STOP;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        state_d = S_IDLE;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    tick_d  = '0;
                end
            endcase
        end
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    // Control and serialiser registers; reset aborts any frame in flight
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset: entries are only read after a push
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    assign bus.din_ready = (count_q != FULL);
    assign bus.tx        = tx_q;
    assign bus.busy      = (state_q != S_IDLE) || (count_q != '0);
    assign bus.count     = count_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: doc/enc_tx_buffer.md
Name: enc_tx_buffer

Overview:
- Downstream consumer of the encrypt/decrypt stage.
- Captures each produced cipher byte into a small FIFO, then serialises it onto a single-wire UART-style line: start bit, 8 data bits LSB first, even parity bit, stop bit.
- Decouples the bursty byte output of the cipher stage from the slower serial link.
- Reports FIFO occupancy and a sticky overflow flag.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CLKS_PER_BIT, 4, CLK cycles each serial bit is held; minimum 1.

Ports:
- CLK  input  1  system clock; all logic on posedge.
- RST  input  1  synchronous active-high reset.
- din  input  8  cipher byte from the upstream stage.
- din_valid  input  1  din is valid this cycle.
- din_ready  output  1  FIFO can accept a byte; combinational, equals (count != DEPTH).
- tx  output  1  serial line; idle high; registered.
- busy  output  1  high when state != IDLE or count != 0.
- count  output  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky flag: a byte was offered while the FIFO was full.

Behaviour:
- Interface: one clock, CLK; reset RST is synchronous and active-high.
- Reset (RST sampled high at a posedge):
  - tx=1, count=0, overflow=0, state=IDLE, FIFO pointers=0, bit counters=0.
  - busy=0 and din_ready=1 after the reset edge.
  - Reset mid-frame aborts the frame: tx returns to 1 at that same edge, and queued bytes are discarded.
- Push:
  - Occurs when din_valid && din_ready at a posedge; din is written at the write pointer, which wraps modulo DEPTH.
  - din_valid while full: byte dropped, overflow set to 1, FIFO unchanged.
  - overflow clears only on RST.
- Pop:
  - Occurs only on entry to START. The head byte is loaded into the shift register, its even parity (XOR of the 8 bits) is latched, and the read pointer wraps modulo DEPTH.
- Same-edge push and pop: count unchanged, both pointers advance. din_ready is evaluated on pre-edge count, so a full FIFO rejects the push even if a pop occurs on that edge.
- FSM (each bit state lasts exactly CLKS_PER_BIT cycles, timed by a cycle counter):
  - IDLE: tx=1. If count>0, pop and go to START at the next edge.
  - START: tx=0, then DATA.
  - DATA: tx=shift[0]; shift right after each bit; after the 8th bit, go to PARITY.
  - PARITY: tx=latched parity, then STOP.
  - STOP: tx=1. On its final cycle, if count>0, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Timing:
  - A frame is 11*CLKS_PER_BIT cycles.
  - Latency: a byte pushed at edge k into an empty, idle block drives tx=0 from edge k+1.
  - tx is registered with its state, so there are no glitches.
- Width rules: count spans 0..DEPTH inclusive. Pointers are log2(DEPTH) bits and wrap naturally.

Test Plan:
- Single byte, CLKS_PER_BIT=4: push 0x5A at edge 0. From edge 1, tx = 0 (4 cycles), then data bits 0,1,0,1,1,0,1,0 (4 cycles each), parity 0 (4 cycles), stop 1 (4 cycles). busy falls after 44 cycles; count returns to 0.
- Parity check: push 0x07 → parity bit 1; push 0x00 → parity bit 0, and all 8 data bits are 0.
- Back-to-back: push 0x11, 0x22, 0x33 on consecutive cycles. Three frames are sent with no idle cycle between the stop bit and the next start bit. count peaks at 2, because the first byte pops immediately.
- Overflow: while frame 1 is in flight, hold din_valid for 6 cycles with bytes 0xA0..0xA5. The first 4 are accepted (0xA0..0xA3), din_ready drops, and overflow goes to 1 and stays there. Only 0xA0..0xA3 appear on tx, in order.
- Simultaneous push/pop at full: FIFO full at the end of a STOP bit, push 0xC3 on that edge → push rejected (overflow=1), pop occurs, count = DEPTH-1.
- Reset mid-frame: assert RST during DATA bit 3 of 0xFF with 2 bytes queued. At the next edge tx=1, count=0, busy=0, overflow=0. No further frames are sent until a new push.
